// File: rtl/mem_arbiter_if.sv
// Requester and backing-memory bundle for mem_arbiter: N packed requester
// channels on one side, a single READ/WRITE/BUSYWAIT memory port on the other.
interface mem_arbiter_if #(
    parameter int NCH    = 2,
    parameter int ADDR_W = 6,
    parameter int DATA_W = 128
);
    localparam int GW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [NCH-1:0]        REQ_READ;
    logic [NCH-1:0]        REQ_WRITE;
    logic [NCH*ADDR_W-1:0] REQ_ADDRESS;
    logic [NCH*DATA_W-1:0] REQ_WRITEDATA;
    logic [DATA_W-1:0]     REQ_READDATA;
    logic [NCH-1:0]        REQ_BUSYWAIT;
    logic [GW-1:0]         GRANT;
    logic                  MEM_READ;
    logic                  MEM_WRITE;
    logic [ADDR_W-1:0]     MEM_ADDRESS;
    logic [DATA_W-1:0]     MEM_WRITEDATA;
    logic [DATA_W-1:0]     MEM_READDATA;
    logic                  MEM_BUSYWAIT;

    // Environment side: requesters plus the memory model
    modport master (
        output REQ_READ, REQ_WRITE, REQ_ADDRESS, REQ_WRITEDATA,
        output MEM_READDATA, MEM_BUSYWAIT,
        input  REQ_READDATA, REQ_BUSYWAIT, GRANT,
        input  MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
    );

    // Arbiter side
    modport slave (
        input  REQ_READ, REQ_WRITE, REQ_ADDRESS, REQ_WRITEDATA,
        input  MEM_READDATA, MEM_BUSYWAIT,
        output REQ_READDATA, REQ_BUSYWAIT, GRANT,
        output MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
    );
endinterface

// File: rtl/mem_arbiter.sv
// N-channel arbiter sharing one READ/WRITE/BUSYWAIT memory port between
// cache requesters; fixed-priority (MODE=0) or round-robin (MODE=1).
module mem_arbiter #(
    parameter int NCH    = 2,
    parameter int ADDR_W = 6,
    parameter int DATA_W = 128,
    parameter int MODE   = 0
) (
    input  logic          CLK,
    input  logic          RESET,
    mem_arbiter_if.slave  bus
);
    localparam int GW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [GW-1:0]     grant_q, grant_d;
    logic [GW-1:0]     ptr_q, ptr_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic [NCH-1:0]    req_any_s;
    logic [NCH-1:0]    busy_s;
    logic [GW-1:0]     base_s;
    logic [GW:0]       sum_s;
    logic [GW-1:0]     idx_s;
    logic [GW-1:0]     winner_s;
    logic              found_s;

    assign req_any_s = bus.REQ_READ | bus.REQ_WRITE;

    // Winner search: first requester at or after base, wrapping modulo NCH
    always_comb begin
        base_s   = (MODE == 1) ? ptr_q : '0;
        winner_s = '0;
        found_s  = 1'b0;
        sum_s    = '0;
        idx_s    = '0;
        for (int k = 0; k < NCH; k++) begin
            sum_s = {1'b0, base_s} + (GW+1)'(k);
            if (sum_s >= (GW+1)'(NCH)) begin
                sum_s = sum_s - (GW+1)'(NCH);
            end else begin
                sum_s = sum_s;
            end
            idx_s = sum_s[GW-1:0];
            if (!found_s && req_any_s[idx_s]) begin
                winner_s = idx_s;
                found_s  = 1'b1;
            end else begin
                found_s  = found_s;
            end
        end
    end

    // Transaction FSM next-state and datapath capture
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        ptr_d       = ptr_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        case (state_q)
            IDLE: begin
                if (found_s) begin
                    // READ and WRITE together on one channel is served as a write
                    grant_d     = winner_s;
                    addr_d      = bus.REQ_ADDRESS[winner_s*ADDR_W +: ADDR_W];
                    wdata_d     = bus.REQ_WRITEDATA[winner_s*DATA_W +: DATA_W];
                    mem_write_d = bus.REQ_WRITE[winner_s];
                    mem_read_d  = ~bus.REQ_WRITE[winner_s];
                    state_d     = REQ;
                end else begin
                    state_d     = IDLE;
                end
            end
            REQ: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (!bus.MEM_BUSYWAIT) begin
                    if (mem_read_q) begin
                        rdata_d = bus.MEM_READDATA;
                    end else begin
                        rdata_d = rdata_q;
                    end
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    state_d     = DONE;
                end else begin
                    state_d     = WAIT;
                end
            end
            DONE: begin
                state_d = IDLE;
                if (MODE == 1) begin
                    ptr_d = (grant_q == GW'(NCH - 1)) ? '0 : grant_q + GW'(1);
                end else begin
                    ptr_d = ptr_q;
                end
            end
            default: begin
                state_d     = IDLE;
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
            end
        endcase
    end

    // Requesters stall until their own DONE cycle
    always_comb begin
        busy_s = '0;
        for (int i = 0; i < NCH; i++) begin
            busy_s[i] = req_any_s[i] & ~((state_q == DONE) && (grant_q == GW'(i)));
        end
    end

    // State and datapath registers
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            ptr_q       <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            ptr_q       <= ptr_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
        end
    end

    assign bus.REQ_READDATA  = rdata_q;
    assign bus.REQ_BUSYWAIT  = busy_s;
    assign bus.GRANT         = grant_q;
    assign bus.MEM_READ      = mem_read_q;
    assign bus.MEM_WRITE     = mem_write_q;
    assign bus.MEM_ADDRESS   = addr_q;
    assign bus.MEM_WRITEDATA = wdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a 2-channel fixed-priority and a 4-channel round-robin
// instance, both checked every cycle against a transaction-level model.
module tb_mem_arbiter;
    localparam int AW = 6;
    localparam int DW = 128;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_arbiter_if #(.NCH(2), .ADDR_W(AW), .DATA_W(DW)) bus0();
    mem_arbiter_if #(.NCH(4), .ADDR_W(AW), .DATA_W(DW)) bus1();

    mem_arbiter #(.NCH(2), .ADDR_W(AW), .DATA_W(DW), .MODE(0)) u0 (.CLK(clk), .RESET(rst), .bus(bus0));
    mem_arbiter #(.NCH(4), .ADDR_W(AW), .DATA_W(DW), .MODE(1)) u1 (.CLK(clk), .RESET(rst), .bus(bus1));

    // Stimulus storage, indexed [instance][channel]
    logic [3:0]    rd_v[2], wr_v[2];
    logic [AW-1:0] ad_v[2][4];
    logic [DW-1:0] wd_v[2][4];
    logic          busy_v[2];
    logic [DW-1:0] mrd_v[2];

    assign bus0.REQ_READ     = rd_v[0][1:0];
    assign bus0.REQ_WRITE    = wr_v[0][1:0];
    assign bus0.MEM_BUSYWAIT = busy_v[0];
    assign bus0.MEM_READDATA = mrd_v[0];
    assign bus1.REQ_READ     = rd_v[1];
    assign bus1.REQ_WRITE    = wr_v[1];
    assign bus1.MEM_BUSYWAIT = busy_v[1];
    assign bus1.MEM_READDATA = mrd_v[1];
    for (genvar g = 0; g < 2; g++) begin : g_b0
        assign bus0.REQ_ADDRESS[g*AW +: AW]   = ad_v[0][g];
        assign bus0.REQ_WRITEDATA[g*DW +: DW] = wd_v[0][g];
    end
    for (genvar g = 0; g < 4; g++) begin : g_b1
        assign bus1.REQ_ADDRESS[g*AW +: AW]   = ad_v[1][g];
        assign bus1.REQ_WRITEDATA[g*DW +: DW] = wd_v[1][g];
    end

    logic          o_mr[2], o_mw[2];
    logic [AW-1:0] o_ad[2];
    logic [DW-1:0] o_wd[2], o_rdat[2];
    logic [1:0]    o_gr[2];
    logic [3:0]    o_bw[2];
    always_comb begin
        o_mr[0] = bus0.MEM_READ;      o_mr[1] = bus1.MEM_READ;
        o_mw[0] = bus0.MEM_WRITE;     o_mw[1] = bus1.MEM_WRITE;
        o_ad[0] = bus0.MEM_ADDRESS;   o_ad[1] = bus1.MEM_ADDRESS;
        o_wd[0] = bus0.MEM_WRITEDATA; o_wd[1] = bus1.MEM_WRITEDATA;
        o_rdat[0] = bus0.REQ_READDATA; o_rdat[1] = bus1.REQ_READDATA;
        o_gr[0] = {1'b0, bus0.GRANT}; o_gr[1] = bus1.GRANT;
        o_bw[0] = {2'b00, bus0.REQ_BUSYWAIT}; o_bw[1] = bus1.REQ_BUSYWAIT;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: one in-flight transaction per instance
    int            nch[2], mode[2];
    bit            m_busy[2], m_done[2], m_wr[2];
    int            m_age[2], m_grant[2], m_ptr[2];
    logic [AW-1:0] m_addr[2];
    logic [DW-1:0] m_wdata[2], m_rdata[2];

    task automatic model_reset();
        for (int n = 0; n < 2; n++) begin
            m_busy[n] = 0; m_done[n] = 0; m_wr[n] = 0; m_age[n] = 0;
            m_grant[n] = 0; m_ptr[n] = 0; m_addr[n] = '0; m_wdata[n] = '0; m_rdata[n] = '0;
        end
    endtask

    task automatic model_step(input int n);
        int idx;
        bit found;
        if (!m_busy[n]) begin
            found = 0;
            for (int k = 0; k < nch[n]; k++) begin
                idx = ((mode[n] == 1 ? m_ptr[n] : 0) + k) % nch[n];
                if (!found && (rd_v[n][idx] || wr_v[n][idx])) begin
                    found = 1; m_busy[n] = 1; m_done[n] = 0; m_age[n] = 0;
                    m_grant[n] = idx; m_wr[n] = wr_v[n][idx];
                    m_addr[n] = ad_v[n][idx]; m_wdata[n] = wd_v[n][idx];
                end
            end
        end else if (m_done[n]) begin
            m_busy[n] = 0; m_done[n] = 0;
            if (mode[n] == 1) m_ptr[n] = (m_grant[n] + 1) % nch[n];
        end else begin
            if (m_age[n] >= 1 && !busy_v[n]) begin
                m_done[n] = 1;
                if (!m_wr[n]) m_rdata[n] = mrd_v[n];
            end
            m_age[n]++;
        end
    endtask

    task automatic check_all();
        logic [3:0] ebw;
        bit emr, emw;
        for (int n = 0; n < 2; n++) begin
            emr = m_busy[n] && !m_done[n] && !m_wr[n];
            emw = m_busy[n] && !m_done[n] && m_wr[n];
            ebw = 4'b0000;
            for (int c = 0; c < nch[n]; c++)
                ebw[c] = (rd_v[n][c] | wr_v[n][c]) & !(m_busy[n] && m_done[n] && m_grant[n] == c);
            chk($sformatf("i%0d_mem_read", n), o_mr[n], emr);
            chk($sformatf("i%0d_mem_write", n), o_mw[n], emw);
            chk($sformatf("i%0d_busywait", n), o_bw[n], ebw);
            chk($sformatf("i%0d_grant", n), o_gr[n], m_grant[n][1:0]);
            chk($sformatf("i%0d_readdata", n), o_rdat[n], m_rdata[n]);
            if (emr || emw || rst) chk($sformatf("i%0d_mem_addr", n), o_ad[n], m_addr[n]);
            if (emw || rst) chk($sformatf("i%0d_mem_wdata", n), o_wd[n], m_wdata[n]);
        end
    endtask

    // Memory model and random requesters
    bit            mem_started[2];
    int            mcnt[2], fix_lat[2];
    bit            fix_dat_en[2];
    logic [DW-1:0] fix_dat[2];
    bit            rand_en[2];
    bit            served[2][4];

    task automatic mem_drive(input int n);
        if (o_mr[n] || o_mw[n]) begin
            if (!mem_started[n]) begin
                mem_started[n] = 1;
                mcnt[n] = (fix_lat[n] >= 0) ? fix_lat[n] : int'($urandom_range(0, 4));
                mrd_v[n] = fix_dat_en[n] ? fix_dat[n] : {$urandom(), $urandom(), $urandom(), $urandom()};
            end
            busy_v[n] = (mcnt[n] > 0);
            if (mcnt[n] > 0) mcnt[n]--;
        end else begin
            mem_started[n] = 0;
            busy_v[n] = 1'b0;
        end
    endtask

    task automatic new_req(input int n, input int c);
        int op;
        op = $urandom_range(0, 2);
        rd_v[n][c] = (op != 1);
        wr_v[n][c] = (op != 0);
        ad_v[n][c] = AW'($urandom());
        wd_v[n][c] = {$urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    task automatic req_update(input int n);
        for (int c = 0; c < nch[n]; c++) begin
            if (served[n][c]) begin
                served[n][c] = 0;
                if ($urandom_range(0, 1) == 1) new_req(n, c);
                else begin rd_v[n][c] = 1'b0; wr_v[n][c] = 1'b0; end
            end else if (!(rd_v[n][c] || wr_v[n][c])) begin
                if ($urandom_range(0, 3) == 0) new_req(n, c);
            end else if ($urandom_range(0, 63) == 0) begin
                rd_v[n][c] = 1'b0; wr_v[n][c] = 1'b0;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst) model_reset();
        else for (int n = 0; n < 2; n++) model_step(n);
        #1;
        for (int n = 0; n < 2; n++) begin
            mem_drive(n);
            if (rand_en[n]) req_update(n);
        end
        @(negedge clk);
        check_all();
        for (int n = 0; n < 2; n++)
            if (rand_en[n])
                for (int c = 0; c < nch[n]; c++)
                    if ((rd_v[n][c] || wr_v[n][c]) && !o_bw[n][c]) served[n][c] = 1;
    endtask

    initial begin
        logic [DW-1:0] a5_pat, wr_pat;
        int nrd, nwr, nlow, bad, nsv, ng, seen;
        int gl[4];
        bit prev;
        a5_pat = {16{8'hA5}};
        wr_pat = 128'h0123456789ABCDEF0123456789ABCDEF;
        nch[0] = 2; nch[1] = 4; mode[0] = 0; mode[1] = 1;
        rst = 1'b1;
        for (int n = 0; n < 2; n++) begin
            rd_v[n] = 4'b0000; wr_v[n] = 4'b0000; busy_v[n] = 1'b0; mrd_v[n] = '0;
            fix_lat[n] = -1; fix_dat_en[n] = 0; fix_dat[n] = '0; rand_en[n] = 0;
            mem_started[n] = 0; mcnt[n] = 0;
            for (int c = 0; c < 4; c++) begin ad_v[n][c] = '0; wd_v[n][c] = '0; served[n][c] = 0; end
        end
        model_reset();
        repeat (2) cycle();
        chk("rst_mem_read", o_mr[0], 1'b0);
        chk("rst_mem_write", o_mw[1], 1'b0);
        chk("rst_addr", o_ad[0], '0);
        chk("rst_rdata", o_rdat[1], '0);
        chk("rst_grant", o_gr[1], 2'd0);
        rst = 1'b0;

        // Single read on ch1, memory busy 5 cycles
        fix_lat[0] = 5; fix_dat_en[0] = 1; fix_dat[0] = a5_pat;
        ad_v[0][1] = 6'h15; rd_v[0] = 4'b0010;
        nrd = 0; nlow = 0; bad = 0;
        for (int t = 0; t < 20; t++) begin
            cycle();
            if (o_mr[0]) begin nrd++; if (nrd == 1) chk("t1_addr", o_ad[0], 6'h15); end
            if (o_bw[0][0]) bad++;
            if (rd_v[0][1] && !o_bw[0][1]) begin
                nlow++; chk("t1_rdata", o_rdat[0], a5_pat); rd_v[0] = 4'b0000;
            end
        end
        chk("t1_read_cycles", nrd, 6);
        chk("t1_bw1_low_cycles", nlow, 1);
        chk("t1_bw0_high", bad, 0);

        // Write on ch0; read data must not move
        fix_lat[0] = 3; fix_dat_en[0] = 0;
        ad_v[0][0] = 6'h2A; wd_v[0][0] = wr_pat; wr_v[0] = 4'b0001;
        nrd = 0; nwr = 0; nlow = 0;
        for (int t = 0; t < 15; t++) begin
            cycle();
            if (o_mw[0]) begin
                nwr++;
                if (nwr == 1) begin chk("t2_addr", o_ad[0], 6'h2A); chk("t2_wdata", o_wd[0], wr_pat); end
            end
            if (o_mr[0]) nrd++;
            if (wr_v[0][0] && !o_bw[0][0]) begin nlow++; wr_v[0] = 4'b0000; end
        end
        chk("t2_write_cycles", nwr, 4);
        chk("t2_no_read", nrd, 0);
        chk("t2_done", nlow, 1);
        chk("t2_rdata_kept", o_rdat[0], a5_pat);

        // Fixed priority: ch0 always re-requests, ch1 starves
        fix_lat[0] = -1; rd_v[0] = 4'b0011; bad = 0; nsv = 0;
        for (int t = 0; t < 40; t++) begin
            cycle();
            if ((o_mr[0] || o_mw[0]) && o_gr[0] != 2'd0) bad++;
            if (!o_bw[0][1]) bad++;
            if (!o_bw[0][0]) nsv++;
        end
        chk("t3_starve", bad, 0);
        chk("t3_ch0_served_3plus", (nsv >= 3), 1'b1);
        rd_v[0] = 4'b0000;
        repeat (10) cycle();

        // Round-robin between ch1 and ch3
        ad_v[1][1] = 6'h11; ad_v[1][3] = 6'h33; rd_v[1] = 4'b1010;
        ng = 0; prev = 0;
        for (int t = 0; t < 60 && ng < 4; t++) begin
            cycle();
            if ((o_mr[1] || o_mw[1]) && !prev) begin gl[ng] = o_gr[1]; ng++; end
            prev = o_mr[1] || o_mw[1];
        end
        chk("t4_grant_count", ng, 4);
        chk("t4_grant0", gl[0], 1);
        chk("t4_grant1", gl[1], 3);
        chk("t4_grant2", gl[2], 1);
        chk("t4_grant3", gl[3], 3);
        rd_v[1] = 4'b0000;
        repeat (12) cycle();

        // Reset pulse during WAIT of a ch1 read
        fix_lat[0] = 6; ad_v[0][1] = 6'h15; rd_v[0] = 4'b0010; nrd = 0;
        for (int t = 0; t < 10 && nrd < 2; t++) begin cycle(); if (o_mr[0]) nrd++; end
        chk("t5_in_wait", nrd, 2);
        #2; rst = 1'b1; model_reset(); #1;
        chk("t5_read_drop_async", o_mr[0], 1'b0);
        cycle();
        rst = 1'b0;
        seen = 0; nlow = 0;
        for (int t = 0; t < 20; t++) begin
            cycle();
            if (o_mr[0] && seen == 0) begin
                seen = 1; chk("t5_reissue_addr", o_ad[0], 6'h15); chk("t5_reissue_grant", o_gr[0], 2'd1);
            end
            if (rd_v[0][1] && !o_bw[0][1]) begin nlow++; rd_v[0] = 4'b0000; end
        end
        chk("t5_reissued", seen, 1);
        chk("t5_done", nlow, 1);

        // READ and WRITE together is a write
        fix_lat[0] = 2; rd_v[0] = 4'b0001; wr_v[0] = 4'b0001; wd_v[0][0] = {4{32'hDEADBEEF}};
        nrd = 0; nwr = 0;
        for (int t = 0; t < 12; t++) begin
            cycle();
            if (o_mw[0]) nwr++;
            if (o_mr[0]) nrd++;
            if (wr_v[0][0] && !o_bw[0][0]) begin rd_v[0] = 4'b0000; wr_v[0] = 4'b0000; end
        end
        chk("t6_write_cycles", nwr, 3);
        chk("t6_no_read", nrd, 0);

        // Randomized traffic on both instances, with one reset pulse
        fix_lat[0] = -1; fix_lat[1] = -1; rand_en[0] = 1; rand_en[1] = 1;
        for (int t = 0; t < 3000; t++) begin
            if (t == 1500) begin
                #2; rst = 1'b1; model_reset(); #1;
                chk("rnd_rst_strobes", {o_mr[0], o_mw[0], o_mr[1], o_mw[1]}, 4'b0000);
                cycle();
                rst = 1'b0;
            end
            cycle();
        end
        rand_en[0] = 0; rand_en[1] = 0;
        for (int n = 0; n < 2; n++) begin rd_v[n] = 4'b0000; wr_v[n] = 4'b0000; end
        repeat (20) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
